// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_pkg
// Purpose  : Shared types and default constants for the unified memory
//            arbiter (FSM state, read-owner tag, parameter defaults).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package unified_mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_if
// Purpose  : Bundles the loader, fetch, data and memory-side signals of the
//            unified memory arbiter.
// Ports    : slave  - arbiter view (requests in, responses/memory strobes out)
//            master - environment view (requests out, responses in)
// Revision : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_data, ld_done,
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ld_req, ld_addr, ld_data, ld_done,
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_starve_ctr
// Purpose  : Saturating count of consecutive fetch denials; raises
//            force_fetch once the count reaches STARVE_MAX.
// Ports    : clk, rst_n (sync, active-low), inc (fetch denied),
//            clr (fetch granted / not requesting), force_fetch (out)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_fetch
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch = (cnt_q == MAX_C);
endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port synchronous-read memory between the
//            program loader, instruction fetch and data access. Sequences the
//            boot load, then arbitrates data (priority) against fetch with a
//            starvation guard, and routes read data back by owner tag.
// Ports    : clk   - system clock
//            Reset - synchronous active-low reset
//            bus   - loader/fetch/data/memory signal bundle (slave modport)
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  Reset,
  unified_mem_arbiter_if.slave  bus
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic in_run, dm_any, data_grant, fetch_grant, ld_write;
  logic force_fetch, starve_inc, starve_clr;

  // Grants: data wins unless the fetch side has been starved long enough.
  always_comb begin
    in_run      = Reset && (state_q == S_RUN);
    dm_any      = bus.dm_rd | bus.dm_wr;
    data_grant  = in_run && dm_any && !(force_fetch && bus.if_req);
    fetch_grant = in_run && bus.if_req && !data_grant;
    ld_write    = Reset && (state_q == S_LOAD) && bus.ld_req;
    starve_inc  = in_run && bus.if_req && !fetch_grant;
    starve_clr  = !in_run || !bus.if_req || fetch_grant;
  end

  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst_n      (Reset),
    .inc        (starve_inc),
    .clr        (starve_clr),
    .force_fetch(force_fetch)
  );

  // Memory strobes; a read+write data request resolves to a write.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = ZERO_ADDR;
    bus.mem_wdata = ZERO_DATA;
    if (ld_write) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_data;
    end else if (data_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dm_wr;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wr ? bus.dm_wdata : ZERO_DATA;
    end else if (fetch_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.if_addr;
    end
  end

  always_comb begin
    bus.if_stall = !in_run || (bus.if_req && !fetch_grant);
    bus.dm_stall = !in_run || (dm_any && !data_grant);
  end

  // Next-state and owner tag of this cycle's granted read.
  always_comb begin
    state_d = state_q;
    if ((state_q == S_LOAD) && bus.ld_done) begin
      state_d = S_RUN;
    end
    owner_d = OWN_NONE;
    if (data_grant && !bus.dm_wr) begin
      owner_d = OWN_DM;
    end else if (fetch_grant) begin
      owner_d = OWN_IF;
    end
  end

  // Read return: valid is gated by Reset so a response pending across a
  // reset assertion is dropped in the very cycle reset is asserted.
  always_comb begin
    bus.if_valid = Reset && (owner_q == OWN_IF);
    bus.dm_valid = Reset && (owner_q == OWN_DM);
    bus.if_rdata = bus.if_valid ? bus.mem_rdata : if_rdata_q;
    bus.dm_rdata = bus.dm_valid ? bus.mem_rdata : dm_rdata_q;
    if_rdata_d   = bus.if_rdata;
    dm_rdata_d   = bus.dm_rdata;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q    <= S_LOAD;
      owner_q    <= OWN_NONE;
      if_rdata_q <= ZERO_DATA;
      dm_rdata_q <= ZERO_DATA;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Self-checking bench for unified_mem_arbiter with a behavioural
//            synchronous-read memory, a reference memory image and per-port
//            read-data scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;
  localparam int SM = 4;

  logic clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory, one-cycle read latency.
  logic [31:0] mem_model [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_addr[7:0]];
    end
  end

  logic [31:0] ref_mem [0:255];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid must match the oldest expected read.
  always @(negedge clk) begin
    if (bus.if_valid === 1'b1) begin
      if (if_q.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
      else chk("if_rdata", bus.if_rdata, if_q.pop_front());
    end
    if (bus.dm_valid === 1'b1) begin
      if (dm_q.size() == 0) chk("dm_valid_unexpected", 32'd1, 32'd0);
      else chk("dm_rdata", bus.dm_rdata, dm_q.pop_front());
    end
  end

  typedef struct {
    logic        if_req;
    logic        dm_rd;
    logic        dm_wr;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_stall;
    logic        e_dm_stall;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    int          e_own;   // 0 none, 1 fetch read, 2 data read
  } vec_t;

  vec_t vecs [9];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_req = 1'b0; bus.ld_done = 1'b0;
    bus.if_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b0;
    idle();
    bus.ld_addr = '0; bus.ld_data = '0; bus.if_addr = '0;
    bus.dm_addr = '0; bus.dm_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd5, 32'd0,  32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 32'd5,  1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd6,  32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 32'd6,  2};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd7,  32'h12345678,   1'b0, 1'b0, 1'b1, 1'b1, 32'd7,  0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'd4, 32'd8,  32'd0,          1'b1, 1'b0, 1'b1, 1'b0, 32'd8,  2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'd9, 32'd10, 32'hCAFEF00D,   1'b1, 1'b0, 1'b1, 1'b1, 32'd10, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd0, 32'd3,  32'hDEADBEEF,   1'b0, 1'b0, 1'b1, 1'b1, 32'd3,  0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd3,  32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 32'd3,  2};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'd7, 32'd0,  32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 32'd7,  1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  0};

    // ---- reset values ----
    next_cycle();
    bus.if_req = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_stall", 32'(bus.if_stall), 32'd1);
    chk("rst_dm_stall", 32'(bus.dm_stall), 32'd1);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    next_cycle();
    Reset = 1'b1;

    // ---- load phase, with fetch requested to show it is ignored ----
    for (int i = 0; i < 16; i++) begin
      bus.ld_req  = 1'b1;
      bus.ld_addr = 32'(i);
      bus.ld_data = (i == 0) ? 32'h20080005 : (i == 1) ? 32'h0 : 32'h10000000 + 32'(i) * 32'h111;
      bus.ld_done = (i == 15);
      bus.if_req  = 1'b1;
      bus.dm_rd   = 1'b1;
      ref_mem[i]  = bus.ld_data;
      @(negedge clk);
      chk("ld_mem_we", 32'(bus.mem_we), 32'd1);
      chk("ld_mem_addr", bus.mem_addr, 32'(i));
      chk("ld_mem_wdata", bus.mem_wdata, ref_mem[i]);
      chk("ld_if_stall", 32'(bus.if_stall), 32'd1);
      chk("ld_dm_stall", 32'(bus.dm_stall), 32'd1);
      next_cycle();
    end
    idle();

    // ---- first fetch in run state ----
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    if_q.push_back(ref_mem[0]);
    @(negedge clk);
    chk("run_if_stall", 32'(bus.if_stall), 32'd0);
    chk("run_mem_addr", bus.mem_addr, 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("boot_if_valid", 32'(bus.if_valid), 32'd1);
    next_cycle();

    // ---- table vectors, each followed by an idle cycle ----
    for (int v = 0; v < 9; v++) begin
      bus.if_req = vecs[v].if_req; bus.dm_rd = vecs[v].dm_rd; bus.dm_wr = vecs[v].dm_wr;
      bus.if_addr = vecs[v].if_addr; bus.dm_addr = vecs[v].dm_addr; bus.dm_wdata = vecs[v].dm_wdata;
      if (vecs[v].e_own == 1) if_q.push_back(ref_mem[vecs[v].if_addr[7:0]]);
      if (vecs[v].e_own == 2) dm_q.push_back(ref_mem[vecs[v].dm_addr[7:0]]);
      @(negedge clk);
      chk($sformatf("v%0d_if_stall", v), 32'(bus.if_stall), 32'(vecs[v].e_if_stall));
      chk($sformatf("v%0d_dm_stall", v), 32'(bus.dm_stall), 32'(vecs[v].e_dm_stall));
      chk($sformatf("v%0d_mem_en", v), 32'(bus.mem_en), 32'(vecs[v].e_en));
      chk($sformatf("v%0d_mem_we", v), 32'(bus.mem_we), 32'(vecs[v].e_we));
      chk($sformatf("v%0d_mem_addr", v), bus.mem_addr, vecs[v].e_addr);
      if (vecs[v].e_we) begin
        chk($sformatf("v%0d_mem_wdata", v), bus.mem_wdata, vecs[v].dm_wdata);
        ref_mem[vecs[v].e_addr[7:0]] = vecs[v].dm_wdata;
      end
      next_cycle();
      idle();
      next_cycle();
    end

    // ---- contention then fetch once data drops ----
    bus.if_req = 1'b1; bus.if_addr = 32'd4; bus.dm_rd = 1'b1; bus.dm_addr = 32'd8;
    dm_q.push_back(ref_mem[8]);
    @(negedge clk);
    chk("cont_if_stall", 32'(bus.if_stall), 32'd1);
    next_cycle();
    bus.dm_rd = 1'b0;
    if_q.push_back(ref_mem[4]);
    @(negedge clk);
    chk("cont_dm_valid", 32'(bus.dm_valid), 32'd1);
    chk("cont_fetch_stall", 32'(bus.if_stall), 32'd0);
    chk("cont_fetch_addr", bus.mem_addr, 32'd4);
    next_cycle();
    idle();
    next_cycle();

    // ---- starvation: fetch forced every SM+1 cycles ----
    bus.if_req = 1'b1; bus.if_addr = 32'd2; bus.dm_rd = 1'b1; bus.dm_addr = 32'd11;
    for (int k = 0; k < 2 * (SM + 1); k++) begin
      logic fetch_turn;
      fetch_turn = ((k % (SM + 1)) == SM);
      if (fetch_turn) if_q.push_back(ref_mem[2]);
      else            dm_q.push_back(ref_mem[11]);
      @(negedge clk);
      chk($sformatf("starve%0d_if_stall", k), 32'(bus.if_stall), 32'(!fetch_turn));
      chk($sformatf("starve%0d_dm_stall", k), 32'(bus.dm_stall), 32'(fetch_turn));
      chk($sformatf("starve%0d_addr", k), bus.mem_addr, fetch_turn ? 32'd2 : 32'd11);
      next_cycle();
    end
    idle();
    next_cycle();

    // ---- reset one cycle after a fetch grant ----
    bus.if_req = 1'b1; bus.if_addr = 32'd1;
    next_cycle();
    Reset = 1'b0;
    @(negedge clk);
    chk("mrst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("mrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("mrst_if_stall", 32'(bus.if_stall), 32'd1);
    next_cycle();
    chk("mrst_if_rdata", bus.if_rdata, 32'd0);
    chk("mrst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("mrst_dm_valid", 32'(bus.dm_valid), 32'd0);
    Reset = 1'b1;
    @(negedge clk);
    chk("reload_if_stall", 32'(bus.if_stall), 32'd1);
    chk("reload_mem_en", 32'(bus.mem_en), 32'd0);
    next_cycle();
    bus.ld_done = 1'b1;
    @(negedge clk);
    chk("done_if_stall", 32'(bus.if_stall), 32'd1);
    next_cycle();
    bus.ld_done = 1'b0;
    bus.if_addr = 32'd0;
    if_q.push_back(ref_mem[0]);
    @(negedge clk);
    chk("post_if_stall", 32'(bus.if_stall), 32'd0);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, synchronous-read memory between three requesters: the program loader, the IF-stage instruction fetch and the MEM-stage data access. It replaces the separate instruction and data memories. The block sequences the boot-time program load, then arbitrates fetch against data access. When a requester loses arbitration, it raises stall outputs that freeze the PC/IFID registers or hold the MEM stage.

## Interface
Parameters:
- ADDR_W, 32, address width of every port
- DATA_W, 32, data width of every port
- STARVE_MAX, 4, number of consecutive fetch denials after which fetch is forced a slot (range 1–15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- ld_req  in  1  loader write request (program load)
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_done  in  1  one-cycle pulse ending the load phase
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  if_rdata valid this cycle
- if_stall  out  1  fetch not granted; hold PC and IF/ID
- dm_rd  in  1  data read request
- dm_wr  in  1  data write request
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  data write data
- dm_rdata  out  DATA_W  data read result
- dm_valid  out  1  dm_rdata valid this cycle
- dm_stall  out  1  data access not granted; hold MEM stage and upstream
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- FSM states are S_LOAD and S_RUN. Reset enters S_LOAD.
- S_LOAD:
  - ld_req drives mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data.
  - if_req, dm_rd and dm_wr are ignored. if_stall=1 and dm_stall=1.
  - ld_done moves the FSM to S_RUN on the next edge. If ld_req is high in the same cycle, that write is still performed.
- S_RUN:
  - ld_req and ld_done are ignored.
  - Data access has priority, except when starve_cnt==STARVE_MAX and if_req=1; then fetch is granted and data is denied.
  - If dm_rd and dm_wr are both high, the access is a write and produces no dm_valid.
- Starvation counter (4-bit):
  - Increments when if_req=1 and fetch is denied.
  - Clears when fetch is granted or when if_req=0.
  - Never exceeds STARVE_MAX.
- Stall outputs:
  - if_stall = if_req & ~fetch_granted.
  - dm_stall = (dm_rd|dm_wr) & ~data_granted.
- Read return:
  - A registered owner tag (NONE/IF/DM) records each granted read.
  - The next cycle, mem_rdata is routed to the tagged port and that port's valid is raised for one cycle.
  - The other port's rdata holds its last value.
- Grant logic and the mem_* outputs are combinational from the current state and requests.

## Timing
- Grant decision and mem_* outputs appear in the same cycle as the request.
- Read data and valid appear one cycle after the grant; each port sees exactly one valid per granted read.
- Writes complete at the grant edge and produce no response.
- Back-to-back grants are allowed every cycle. The memory is fully pipelined at one access per cycle.
- Reset (Reset=0 at an edge) forces:
  - state=S_LOAD, starve_cnt=0, owner tag=NONE
  - if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0
  - While Reset=0: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_stall=1, dm_stall=1.
- Reset mid-read: the pending response is discarded; no valid is raised after reset.
- A fetch forced by starvation clears starve_cnt on the same edge.

## Structure
- Package unified_mem_arbiter_pkg holds:
  - state enum {S_LOAD, S_RUN}
  - owner enum {OWN_NONE, OWN_IF, OWN_DM}
  - default parameter constants
- Sub-module mem_arb_starve_ctr holds the saturating fetch-starvation counter and its force_fetch compare.
- All other logic stays in the top module.

## Test plan
- **Load phase:** after reset, ld_req writes 0x20080005 to addr 0 and 0x00000000 to addr 1, then ld_done pulses. Required:
  - mem_we=1 on both write cycles.
  - if_stall=1 throughout the load.
  - state=S_RUN one cycle after ld_done.
  - A subsequent fetch of addr 0 returns if_rdata=0x20080005 with if_valid one cycle after the grant.
- **Contention:** in S_RUN, if_req and dm_rd are raised together at addr 4 and 8. Required:
  - Data is granted; dm_valid and the addr 8 contents arrive the next cycle.
  - if_stall=1 for that cycle.
  - Fetch is granted the following cycle once dm_rd drops.
- **Starvation:** with STARVE_MAX=4, if_req and dm_rd are held high continuously. Required:
  - Data is granted 4 cycles in a row.
  - Cycle 5 grants fetch with dm_stall=1.
  - The pattern repeats every 5 cycles.
- **Read/write collision:** dm_rd=1 and dm_wr=1 with data 0xDEADBEEF at addr 3. Required: a write is performed, no dm_valid follows, and a later read of addr 3 returns 0xDEADBEEF.
- **Reset mid-operation:** Reset=0 one cycle after a fetch grant. Required:
  - No if_valid is raised.
  - All outputs take their reset values.
  - State returns to S_LOAD, and if_req is ignored until ld_done.
